// File: rtl/demod_pkg.sv
// Shared definitions for the demodulation front end: mode codes used by the core
// and the classifier, plus the classifier's window state and default tuning.
package demod_pkg;

    localparam logic [1:0] MODE_AM   = 2'b00;
    localparam logic [1:0] MODE_BPSK = 2'b01;
    localparam logic [1:0] MODE_FM   = 2'b10;
    localparam logic [1:0] MODE_NONE = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } cls_state_e;

    localparam int DEF_WIN_HC  = 32;
    localparam int DEF_AM_THR  = 16;
    localparam int DEF_FM_THR  = 3;
    localparam int DEF_CONFIRM = 2;
    localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/zc_tracker.sv
// Converts offset-binary samples to sign/magnitude, detects zero crossings and
// reports the peak magnitude and length of each half-cycle as it closes.
module zc_tracker (
    input  logic       clk,
    input  logic       rst,
    input  logic       sample_valid,
    input  logic [7:0] sample,
    output logic       hc_done,
    output logic [6:0] hc_peak,
    output logic [7:0] hc_len
);

    logic       have_prev_q, have_prev_d;
    logic       prev_neg_q, prev_neg_d;
    logic [6:0] peak_q, peak_d;
    logic [7:0] len_q, len_d;

    logic [7:0] s;
    logic [7:0] neg_s;
    logic       neg;
    logic [6:0] mag;

    always_comb begin
        s     = sample ^ 8'h80;
        neg   = s[7];
        neg_s = ~s + 8'd1;
        // -128 has no positive twin in 7 bits, so it clips to 127.
        if (!neg)            mag = s[6:0];
        else if (s == 8'h80) mag = 7'h7f;
        else                 mag = neg_s[6:0];
    end

    always_comb begin
        have_prev_d = have_prev_q;
        prev_neg_d  = prev_neg_q;
        peak_d      = peak_q;
        len_d       = len_q;
        hc_done     = 1'b0;
        hc_peak     = peak_q;
        hc_len      = len_q;
        if (sample_valid) begin
            have_prev_d = 1'b1;
            prev_neg_d  = neg;
            if (have_prev_q && (neg != prev_neg_q)) begin
                hc_done = 1'b1;
                peak_d  = mag;
                len_d   = 8'd1;
            end else if (!have_prev_q) begin
                peak_d = mag;
                len_d  = 8'd1;
            end else begin
                peak_d = (mag > peak_q) ? mag : peak_q;
                len_d  = (len_q == 8'hff) ? len_q : len_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            have_prev_q <= 1'b0;
            prev_neg_q  <= 1'b0;
            peak_q      <= 7'd0;
            len_q       <= 8'd0;
        end else begin
            have_prev_q <= have_prev_d;
            prev_neg_q  <= prev_neg_d;
            peak_q      <= peak_d;
            len_q       <= len_d;
        end
    end

endmodule

// File: rtl/mod_classifier.sv
// Modulation recogniser: gathers per-window envelope and interval spreads,
// classifies each window as AM/BPSK/FM/NONE and debounces the result onto mode_select.
module mod_classifier
    import demod_pkg::*;
#(
    parameter int WIN_HC  = DEF_WIN_HC,
    parameter int AM_THR  = DEF_AM_THR,
    parameter int FM_THR  = DEF_FM_THR,
    parameter int CONFIRM = DEF_CONFIRM,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic [1:0] mode_select,
    output logic       mode_valid,
    output logic       mode_change
);

    localparam int HCW = $clog2(WIN_HC + 1);
    localparam int SCW = $clog2(TIMEOUT + 1);
    localparam logic [HCW-1:0] WIN_L  = HCW'(WIN_HC);
    localparam logic [HCW-1:0] MIN_HC = HCW'(4);
    localparam logic [SCW-1:0] TO_L   = SCW'(TIMEOUT);
    localparam logic [6:0]     AM_L   = 7'(AM_THR);
    localparam logic [7:0]     FM_L   = 8'(FM_THR);
    localparam logic [3:0]     CONF_L = 4'(CONFIRM);

    logic       hc_done;
    logic [6:0] hc_peak;
    logic [7:0] hc_len;

    zc_tracker u_zc (
        .clk          (sys_clk),
        .rst          (sys_rst),
        .sample_valid (data_valid),
        .sample       (data_in),
        .hc_done      (hc_done),
        .hc_peak      (hc_peak),
        .hc_len       (hc_len)
    );

    cls_state_e     state_q, state_d;
    logic [HCW-1:0] hc_cnt_q, hc_cnt_d;
    logic [6:0]     env_min_q, env_min_d, env_max_q, env_max_d;
    logic [7:0]     zc_min_q, zc_min_d, zc_max_q, zc_max_d;
    logic [SCW-1:0] smp_cnt_q, smp_cnt_d;
    logic           snap_valid_q, snap_valid_d;
    logic           snap_to_q, snap_to_d;
    logic [HCW-1:0] snap_hc_q, snap_hc_d;
    logic [6:0]     snap_env_q, snap_env_d;
    logic [7:0]     snap_zc_q, snap_zc_d;
    logic           res_valid_q, res_valid_d;
    logic [1:0]     res_q, res_d;
    logic [1:0]     cand_q, cand_d;
    logic [3:0]     cand_cnt_q, cand_cnt_d;
    logic [1:0]     mode_q, mode_d;
    logic           mode_valid_q, mode_valid_d;
    logic           mode_change_q, mode_change_d;

    logic [6:0]     env_min_f, env_max_f;
    logic [7:0]     zc_min_f, zc_max_f;
    logic [HCW-1:0] hc_f;
    logic [SCW-1:0] smp_inc;
    logic [3:0]     cnt_new;

    // Window accumulation; a closing crossing both finishes this window and opens the next.
    always_comb begin
        state_d      = state_q;
        hc_cnt_d     = hc_cnt_q;
        env_min_d    = env_min_q;
        env_max_d    = env_max_q;
        zc_min_d     = zc_min_q;
        zc_max_d     = zc_max_q;
        smp_cnt_d    = smp_cnt_q;
        snap_valid_d = 1'b0;
        snap_to_d    = snap_to_q;
        snap_hc_d    = snap_hc_q;
        snap_env_d   = snap_env_q;
        snap_zc_d    = snap_zc_q;

        env_min_f = (hc_peak < env_min_q) ? hc_peak : env_min_q;
        env_max_f = (hc_peak > env_max_q) ? hc_peak : env_max_q;
        zc_min_f  = (hc_len < zc_min_q) ? hc_len : zc_min_q;
        zc_max_f  = (hc_len > zc_max_q) ? hc_len : zc_max_q;
        hc_f      = hc_cnt_q + HCW'(1);
        smp_inc   = (smp_cnt_q == TO_L) ? smp_cnt_q : smp_cnt_q + SCW'(1);

        if (data_valid) begin
            smp_cnt_d = smp_inc;
            if (state_q == IDLE) begin
                if (hc_done) state_d = ACCUM;
            end else if (hc_done) begin
                env_min_d = env_min_f;
                env_max_d = env_max_f;
                zc_min_d  = zc_min_f;
                zc_max_d  = zc_max_f;
                hc_cnt_d  = hc_f;
            end

            if ((state_q == ACCUM) && hc_done && (hc_f == WIN_L)) begin
                snap_valid_d = 1'b1;
                snap_to_d    = 1'b0;
                snap_hc_d    = hc_f;
                snap_env_d   = env_max_f - env_min_f;
                snap_zc_d    = zc_max_f - zc_min_f;
            end else if (smp_inc == TO_L) begin
                snap_valid_d = 1'b1;
                snap_to_d    = 1'b1;
                snap_hc_d    = hc_cnt_d;
                snap_env_d   = 7'd0;
                snap_zc_d    = 8'd0;
                state_d      = IDLE;
            end

            if (snap_valid_d) begin
                hc_cnt_d  = '0;
                env_min_d = 7'h7f;
                env_max_d = 7'd0;
                zc_min_d  = 8'hff;
                zc_max_d  = 8'd0;
                smp_cnt_d = '0;
            end
        end
    end

    always_comb begin
        res_valid_d = snap_valid_q;
        res_d       = res_q;
        if (snap_valid_q) begin
            if (snap_to_q || (snap_hc_q < MIN_HC)) res_d = MODE_NONE;
            else if (snap_env_q > AM_L)            res_d = MODE_AM;
            else if (snap_zc_q > FM_L)             res_d = MODE_FM;
            else                                   res_d = MODE_BPSK;
        end
    end

    // Debounce: a mode is only adopted once CONFIRM consecutive windows agree on it.
    always_comb begin
        cand_d        = cand_q;
        cand_cnt_d    = cand_cnt_q;
        mode_d        = mode_q;
        mode_valid_d  = mode_valid_q;
        mode_change_d = 1'b0;
        cnt_new       = 4'd1;
        if (res_valid_q) begin
            if (res_q == cand_q)
                cnt_new = (cand_cnt_q == 4'hf) ? cand_cnt_q : cand_cnt_q + 4'd1;
            cand_d     = res_q;
            cand_cnt_d = cnt_new;
            if ((cnt_new >= CONF_L) && (res_q != mode_q)) begin
                mode_d        = res_q;
                mode_valid_d  = (res_q != MODE_NONE);
                mode_change_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            hc_cnt_q      <= '0;
            env_min_q     <= 7'h7f;
            env_max_q     <= 7'd0;
            zc_min_q      <= 8'hff;
            zc_max_q      <= 8'd0;
            smp_cnt_q     <= '0;
            snap_valid_q  <= 1'b0;
            snap_to_q     <= 1'b0;
            snap_hc_q     <= '0;
            snap_env_q    <= 7'd0;
            snap_zc_q     <= 8'd0;
            res_valid_q   <= 1'b0;
            res_q         <= MODE_NONE;
            cand_q        <= MODE_NONE;
            cand_cnt_q    <= 4'd0;
            mode_q        <= MODE_NONE;
            mode_valid_q  <= 1'b0;
            mode_change_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            hc_cnt_q      <= hc_cnt_d;
            env_min_q     <= env_min_d;
            env_max_q     <= env_max_d;
            zc_min_q      <= zc_min_d;
            zc_max_q      <= zc_max_d;
            smp_cnt_q     <= smp_cnt_d;
            snap_valid_q  <= snap_valid_d;
            snap_to_q     <= snap_to_d;
            snap_hc_q     <= snap_hc_d;
            snap_env_q    <= snap_env_d;
            snap_zc_q     <= snap_zc_d;
            res_valid_q   <= res_valid_d;
            res_q         <= res_d;
            cand_q        <= cand_d;
            cand_cnt_q    <= cand_cnt_d;
            mode_q        <= mode_d;
            mode_valid_q  <= mode_valid_d;
            mode_change_q <= mode_change_d;
        end
    end

    assign mode_select = mode_q;
    assign mode_valid  = mode_valid_q;
    assign mode_change = mode_change_q;

endmodule

// File: tb/tb_mod_classifier.sv
// Directed bench for mod_classifier: table of carrier patterns with expected
// debounced decisions, plus hand sequences for reset, latency, glitch and timeout.
module tb_mod_classifier;

    logic       sys_clk;
    logic       sys_rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic [1:0] mode_select;
    logic       mode_valid;
    logic       mode_change;

    int checks;
    int errors;
    int chg_cnt;
    logic cur_pos;

    mod_classifier dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .mode_select (mode_select),
        .mode_valid  (mode_valid),
        .mode_change (mode_change)
    );

    initial sys_clk = 1'b0;
    always #10 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (mode_change === 1'b1) chg_cnt = chg_cnt + 1;
    end

    typedef struct {
        logic       do_rst;
        int         pat;      // 0 BPSK, 1 AM (100/60), 2 FM (3/7 samples)
        int         n_hc;
        int         gap;
        logic [1:0] exp_mode;
        logic       exp_valid;
        int         exp_chg;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] enc(input logic pos, input int amp);
        logic [7:0] a;
        a = 8'(amp);
        return pos ? (8'h80 + a) : (8'h80 - a);
    endfunction

    task automatic drive_sample(input logic [7:0] v, input int gap);
        data_in    = v;
        data_valid = 1'b1;
        @(posedge sys_clk);
        #1;
        data_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            data_in = 8'($urandom_range(0, 255));
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic send_hc(input int amp, input int len, input int gap);
        cur_pos = ~cur_pos;
        for (int k = 0; k < len; k++) drive_sample(enc(cur_pos, amp), gap);
    endtask

    task automatic send_pattern(input int pat, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            if (pat == 1)      send_hc((i % 2 == 1) ? 60 : 100, 4, gap);
            else if (pat == 2) send_hc(100, (i % 2 == 1) ? 7 : 3, gap);
            else               send_hc(100, 4, gap);
        end
    endtask

    task automatic idle(input int n);
        data_valid = 1'b0;
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        data_valid = 1'b0;
        sys_rst    = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cur_pos = 1'b0;
        idle(2);
    endtask

    initial begin
        int c0;
        checks     = 0;
        errors     = 0;
        chg_cnt    = 0;
        cur_pos    = 1'b0;
        data_in    = 8'h80;
        data_valid = 1'b0;
        sys_rst    = 1'b0;

        vecs[0] = '{1'b0, 0, 96,  0, 2'b01, 1'b1, 1};
        vecs[1] = '{1'b0, 1, 128, 0, 2'b00, 1'b1, 1};
        vecs[2] = '{1'b0, 2, 128, 0, 2'b10, 1'b1, 1};
        vecs[3] = '{1'b0, 0, 128, 0, 2'b01, 1'b1, 1};
        vecs[4] = '{1'b1, 0, 96,  9, 2'b01, 1'b1, 1};
        vecs[5] = '{1'b0, 1, 128, 9, 2'b00, 1'b1, 1};

        #5;
        do_reset();
        check("reset_mode", int'(mode_select), 3);
        check("reset_valid", int'(mode_valid), 0);
        check("reset_change_cnt", chg_cnt, 0);

        for (int r = 0; r < 4; r++) begin
            c0 = chg_cnt;
            send_pattern(vecs[r].pat, vecs[r].n_hc, vecs[r].gap);
            idle(5);
            check($sformatf("row%0d_mode", r), int'(mode_select), int'(vecs[r].exp_mode));
            check($sformatf("row%0d_valid", r), int'(mode_valid), int'(vecs[r].exp_valid));
            check($sformatf("row%0d_changes", r), chg_cnt - c0, vecs[r].exp_chg);
        end

        // Reset asserted mid-window takes effect without waiting for a clock edge.
        send_pattern(0, 10, 0);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        #1;
        check("midrst_mode", int'(mode_select), 3);
        check("midrst_valid", int'(mode_valid), 0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        cur_pos = 1'b0;
        idle(2);

        // Fresh stream: hc1 partial, windows are hc2-33 and hc34-65, closed by hc66's first sample.
        c0 = chg_cnt;
        send_pattern(0, 65, 0);
        idle(3);
        check("pre_lock_mode", int'(mode_select), 3);
        cur_pos = ~cur_pos;
        drive_sample(enc(cur_pos, 100), 0);
        @(posedge sys_clk);
        #1;
        check("latency_1clk_mode", int'(mode_select), 3);
        @(posedge sys_clk);
        #1;
        check("latency_2clk_mode", int'(mode_select), 1);
        check("latency_2clk_change", int'(mode_change), 1);
        check("latency_2clk_valid", int'(mode_valid), 1);
        for (int k = 0; k < 3; k++) drive_sample(enc(cur_pos, 100), 0);
        for (int i = 0; i < 31; i++) send_hc((i % 2 == 0) ? 60 : 100, 4, 0);
        send_pattern(0, 64, 0);
        idle(5);
        check("glitch_mode", int'(mode_select), 1);
        check("glitch_changes", chg_cnt - c0, 1);

        // Flat input never crosses zero: only sample-count timeouts close windows.
        c0 = chg_cnt;
        for (int k = 0; k < 2 * 1024 + 16; k++) drive_sample(8'h90, 0);
        idle(5);
        check("timeout_mode", int'(mode_select), 3);
        check("timeout_valid", int'(mode_valid), 0);
        check("timeout_changes", chg_cnt - c0, 1);

        for (int r = 4; r < 6; r++) begin
            if (vecs[r].do_rst) do_reset();
            c0 = chg_cnt;
            send_pattern(vecs[r].pat, vecs[r].n_hc, vecs[r].gap);
            idle(5);
            check($sformatf("row%0d_mode", r), int'(mode_select), int'(vecs[r].exp_mode));
            check($sformatf("row%0d_valid", r), int'(mode_valid), int'(vecs[r].exp_valid));
            check($sformatf("row%0d_changes", r), chg_cnt - c0, vecs[r].exp_chg);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
